// File: rtl/main_mem_responder_if.sv
// main_mem_responder_if
//   Request/response bundle between a cache-side requester and the
//   main-memory responder.
//   Request channel : req_valid, req_ready, req_write, req_addr, req_wdata
//   Response channel: resp_valid, resp_ready, resp_write, resp_rdata
//   modport master : requester side (drives the request, accepts the response)
//   modport slave  : responder side (accepts the request, drives the response)
interface main_mem_responder_if #(
   parameter int unsigned LINE_LEN = 128,
   parameter int unsigned ADDR_LEN = 32
);
   logic                req_valid;
   logic                req_ready;
   logic                req_write;
   logic [ADDR_LEN-1:0] req_addr;
   logic [LINE_LEN-1:0] req_wdata;
   logic                resp_valid;
   logic                resp_ready;
   logic                resp_write;
   logic [LINE_LEN-1:0] resp_rdata;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_write, resp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_write, resp_rdata
   );
endinterface

// File: rtl/main_mem_responder.sv
// main_mem_responder
//   Behavioural main memory with a fixed request-to-response latency.
//   One line-sized transaction is served at a time (IDLE -> BUSY -> RESP).
//   Ports:
//     clk      : clock, all state changes on its rising edge
//     reset_n  : asynchronous active-low reset (array contents are kept)
//     bus      : slave side of main_mem_responder_if (request + response)
module main_mem_responder #(
   parameter int unsigned LINE_LEN  = 128,
   parameter int unsigned ADDR_LEN  = 32,
   parameter int unsigned NUM_LINES = 256,
   parameter int unsigned LATENCY   = 5
) (
   input  logic                clk,
   input  logic                reset_n,
   main_mem_responder_if.slave bus
);

   localparam int unsigned OFF_W    = $clog2(LINE_LEN / 8);
   localparam int unsigned IDX_W    = $clog2(NUM_LINES);
   localparam int unsigned CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int unsigned CNT_LOAD = (LATENCY > 1) ? LATENCY - 2 : 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                wr_q, wr_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [LINE_LEN-1:0] wdata_q, wdata_d;
   logic                resp_write_q, resp_write_d;
   logic [LINE_LEN-1:0] resp_rdata_q, resp_rdata_d;

   logic [LINE_LEN-1:0] mem_q [NUM_LINES];

   logic [IDX_W-1:0]    req_idx;
   logic                enter_resp;
   logic                acc_write;
   logic [IDX_W-1:0]    acc_idx;
   logic [LINE_LEN-1:0] acc_wdata;
   logic                mem_we;
   logic                unused_addr_bits;

   // Offset and upper address bits are dropped, so addresses alias per line.
   assign req_idx          = bus.req_addr[OFF_W +: IDX_W];
   assign unused_addr_bits = ^bus.req_addr;

   // With LATENCY=1 the array is accessed on the accepting edge itself, so
   // the request inputs are used directly instead of the captured copy.
   assign acc_write = (state_q == IDLE) ? bus.req_write : wr_q;
   assign acc_idx   = (state_q == IDLE) ? req_idx       : idx_q;
   assign acc_wdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      wr_d         = wr_q;
      idx_d        = idx_q;
      wdata_d      = wdata_q;
      enter_resp   = 1'b0;
      resp_write_d = resp_write_q;
      resp_rdata_d = resp_rdata_q;

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               wr_d    = bus.req_write;
               idx_d   = req_idx;
               wdata_d = bus.req_wdata;
               if (LATENCY == 1) begin
                  state_d    = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = BUSY;
                  cnt_d   = CNT_W'(CNT_LOAD);
               end
            end
         end
         BUSY: begin
            if (cnt_q == '0) begin
               state_d    = RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            if (bus.resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (enter_resp) begin
         resp_write_d = acc_write;
         resp_rdata_d = acc_write ? acc_wdata : mem_q[acc_idx];
      end
   end

   // Gated with reset_n because the array has no reset and req_ready is
   // high while reset is held.
   assign mem_we = enter_resp & acc_write & reset_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         wr_q         <= 1'b0;
         idx_q        <= '0;
         wdata_q      <= '0;
         resp_write_q <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         wr_q         <= wr_d;
         idx_q        <= idx_d;
         wdata_q      <= wdata_d;
         resp_write_q <= resp_write_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[acc_idx] <= acc_wdata;
      end
   end

   assign bus.req_ready  = (state_q == IDLE);
   assign bus.resp_valid = (state_q == RESP);
   assign bus.resp_write = resp_write_q;
   assign bus.resp_rdata = resp_rdata_q;

endmodule
